id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 32-bit MIPS pipeline, directly upstream of the ALU. Decodes the fetched instruction into ALU control fields (`amt_sel`, `logic_func`, `shift_func`, `add_sub`, `final_func`), selects operands and destination, and registers everything into the EX stage with stall/flush control. When forwarding is enabled, it also applies EX/MEM and MEM/WB operand forwarding to the registered operands, so the ALU sees resolved values.

---
 rtl/mips_pkg.sv | 103 ++++++++++
 rtl/id_ex_stage_alu_ctrl_decode.sv | 101 ++++++++++
 rtl/id_ex_stage.sv | 133 +++++++++++++
 tb/tb_id_ex_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct constants, ALU control encodings,
// branch types and the ID/EX register record.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  localparam logic [1:0] FF_SHIFT = 2'b00;
  localparam logic [1:0] FF_SLT   = 2'b01;
  localparam logic [1:0] FF_ADD   = 2'b10;
  localparam logic [1:0] FF_LOGIC = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SLL  = 2'b01;
  localparam logic [1:0] SH_SRL  = 2'b10;
  localparam logic [1:0] SH_SRA  = 2'b11;

  localparam logic [1:0] LG_AND = 2'b00;
  localparam logic [1:0] LG_OR  = 2'b01;
  localparam logic [1:0] LG_XOR = 2'b10;
  localparam logic [1:0] LG_NOR = 2'b11;

  localparam logic [1:0] AMT_CONST = 2'b00;
  localparam logic [1:0] AMT_REG   = 2'b01;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_EQ   = 2'b01;
  localparam logic [1:0] BR_NE   = 2'b10;

  typedef enum logic [1:0] {YSEL_RT, YSEL_SEXT, YSEL_ZEXT} ysel_e;
  typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT} dsel_e;

  typedef struct packed {
    logic [4:0] const_amt;
    logic [1:0] amt_sel;
    logic [1:0] logic_func;
    logic [1:0] shift_func;
    logic       add_sub;
    logic [1:0] final_func;
    ysel_e      ysel;
    dsel_e      dsel;
    logic       memread;
    logic       memwrite;
    logic [1:0] branch;
    logic       ovf_trap;
    logic       illegal;
  } dec_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  const_amt;
    logic [1:0]  amt_sel;
    logic [1:0]  logic_func;
    logic [1:0]  shift_func;
    logic        add_sub;
    logic [1:0]  final_func;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [31:0] store_data;
    logic [1:0]  branch;
    logic        ovf_trap;
    logic        illegal;
  } ex_out_t;

  // Bubble differs from the reset image only in final_func selecting the adder.
  function automatic ex_out_t ex_bubble();
    ex_out_t b;
    b = '0;
    b.final_func = FF_ADD;
    return b;
  endfunction

endpackage

// File: rtl/id_ex_stage_alu_ctrl_decode.sv
// Combinational decode of a MIPS instruction into ALU control fields,
// operand/destination selects, memory/branch controls and the illegal flag.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [31:0] instr_i,
  output dec_t        dec_o
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] shamt;
  logic       unused_fields;

  assign op            = instr_i[31:26];
  assign funct         = instr_i[5:0];
  assign shamt         = instr_i[10:6];
  assign unused_fields = ^instr_i[25:11];

  always_comb begin
    dec_o            = '0;
    dec_o.final_func = FF_ADD;
    dec_o.ysel       = YSEL_RT;
    dec_o.dsel       = DST_NONE;
    case (op)
      OP_RTYPE: begin
        dec_o.dsel = DST_RD;
        case (funct)
          F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: begin
            // funct[2] marks the variable-amount forms; funct[1:0]=00 is a left shift
            dec_o.final_func = FF_SHIFT;
            dec_o.amt_sel    = funct[2] ? AMT_REG : AMT_CONST;
            dec_o.const_amt  = funct[2] ? 5'd0 : shamt;
            dec_o.shift_func = (funct[1:0] == 2'b00) ? SH_SLL : funct[1:0];
          end
          F_ADD, F_SUB: begin
            dec_o.add_sub  = funct[1];
            dec_o.ovf_trap = 1'b1;
          end
          F_ADDU, F_SUBU: dec_o.add_sub = funct[1];
          F_AND, F_OR, F_XOR, F_NOR: begin
            dec_o.final_func = FF_LOGIC;
            dec_o.logic_func = funct[1:0];
          end
          F_SLT: begin
            dec_o.final_func = FF_SLT;
            dec_o.add_sub    = 1'b1;
          end
          default: begin
            dec_o.illegal = 1'b1;
            dec_o.dsel    = DST_NONE;
          end
        endcase
      end
      OP_ADDI: begin
        dec_o.ysel     = YSEL_SEXT;
        dec_o.dsel     = DST_RT;
        dec_o.ovf_trap = 1'b1;
      end
      OP_ADDIU: begin
        dec_o.ysel = YSEL_SEXT;
        dec_o.dsel = DST_RT;
      end
      OP_SLTI: begin
        dec_o.ysel       = YSEL_SEXT;
        dec_o.dsel       = DST_RT;
        dec_o.final_func = FF_SLT;
        dec_o.add_sub    = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_o.ysel       = YSEL_ZEXT;
        dec_o.dsel       = DST_RT;
        dec_o.final_func = FF_LOGIC;
        dec_o.logic_func = op[1:0];
      end
      OP_LUI: begin
        dec_o.ysel       = YSEL_ZEXT;
        dec_o.dsel       = DST_RT;
        dec_o.final_func = FF_SHIFT;
        dec_o.shift_func = SH_SLL;
        dec_o.amt_sel    = AMT_CONST;
        dec_o.const_amt  = 5'd16;
      end
      OP_LW: begin
        dec_o.ysel    = YSEL_SEXT;
        dec_o.dsel    = DST_RT;
        dec_o.memread = 1'b1;
      end
      OP_SW: begin
        dec_o.ysel     = YSEL_SEXT;
        dec_o.memwrite = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        dec_o.add_sub = 1'b1;
        dec_o.branch  = (op == OP_BEQ) ? BR_EQ : BR_NE;
      end
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with decode, operand selection and stall/flush control.
// Optional EX/MEM and MEM/WB operand forwarding is enabled by ID_EX_FORWARD_EN.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        exmem_wr,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_res,
  input  logic        memwb_wr,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_res,
  output logic        ex_valid,
  output logic [31:0] alu_x,
  output logic [31:0] alu_y,
  output logic [4:0]  const_amt,
  output logic [1:0]  amt_sel,
  output logic [1:0]  logic_func,
  output logic [1:0]  shift_func,
  output logic        add_sub,
  output logic [1:0]  final_func,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic [31:0] ex_store_data,
  output logic [1:0]  ex_branch,
  output logic        ex_ovf_trap,
  output logic        ex_illegal
);

  dec_t        dec;
  ex_out_t     ex_d, ex_q, ld;
  logic [31:0] fwd_rs, fwd_rt;
  logic [4:0]  rt_idx, dst;
  logic [31:0] imm_sext, imm_zext;

  alu_ctrl_decode u_dec (
    .instr_i (instr),
    .dec_o   (dec)
  );

  assign rt_idx   = instr[20:16];
  assign imm_sext = {{16{instr[15]}}, instr[15:0]};
  assign imm_zext = {16'h0000, instr[15:0]};

`ifdef ID_EX_FORWARD_EN
  logic [4:0] rs_idx;
  assign rs_idx = instr[25:21];

  // EX/MEM is applied last so it overrides the older MEM/WB result.
  always_comb begin
    fwd_rs = rs_data;
    fwd_rt = rt_data;
    if (memwb_wr && (memwb_rd != 5'd0) && (memwb_rd == rs_idx)) fwd_rs = memwb_res;
    if (memwb_wr && (memwb_rd != 5'd0) && (memwb_rd == rt_idx)) fwd_rt = memwb_res;
    if (exmem_wr && (exmem_rd != 5'd0) && (exmem_rd == rs_idx)) fwd_rs = exmem_res;
    if (exmem_wr && (exmem_rd != 5'd0) && (exmem_rd == rt_idx)) fwd_rt = exmem_res;
  end
`else
  logic unused_fwd;
  assign fwd_rs     = rs_data;
  assign fwd_rt     = rt_data;
  assign unused_fwd = ^{exmem_wr, exmem_rd, exmem_res, memwb_wr, memwb_rd, memwb_res};
`endif

  always_comb begin
    case (dec.dsel)
      DST_RD:  dst = instr[15:11];
      DST_RT:  dst = rt_idx;
      default: dst = 5'd0;
    endcase
  end

  always_comb begin
    ld            = '0;
    ld.valid      = 1'b1;
    ld.x          = fwd_rs;
    case (dec.ysel)
      YSEL_SEXT: ld.y = imm_sext;
      YSEL_ZEXT: ld.y = imm_zext;
      default:   ld.y = fwd_rt;
    endcase
    ld.const_amt  = dec.const_amt;
    ld.amt_sel    = dec.amt_sel;
    ld.logic_func = dec.logic_func;
    ld.shift_func = dec.shift_func;
    ld.add_sub    = dec.add_sub;
    ld.final_func = dec.final_func;
    ld.rd         = dst;
    ld.regwrite   = (dec.dsel != DST_NONE) && (dst != 5'd0);
    ld.memread    = dec.memread;
    ld.memwrite   = dec.memwrite;
    ld.store_data = fwd_rt;
    ld.branch     = dec.branch;
    ld.ovf_trap   = dec.ovf_trap;
    ld.illegal    = dec.illegal;
  end

  assign ex_d = (flush || !in_valid) ? ex_bubble() : ld;

  // Flush overrides stall, so the register also loads when flushing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 ex_q <= '0;
    else if (flush || !stall) ex_q <= ex_d;
  end

  assign ex_valid      = ex_q.valid;
  assign alu_x         = ex_q.x;
  assign alu_y         = ex_q.y;
  assign const_amt     = ex_q.const_amt;
  assign amt_sel       = ex_q.amt_sel;
  assign logic_func    = ex_q.logic_func;
  assign shift_func    = ex_q.shift_func;
  assign add_sub       = ex_q.add_sub;
  assign final_func    = ex_q.final_func;
  assign ex_rd         = ex_q.rd;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_store_data = ex_q.store_data;
  assign ex_branch     = ex_q.branch;
  assign ex_ovf_trap   = ex_q.ovf_trap;
  assign ex_illegal    = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed instructions push hand-computed EX records,
// a monitor pops and compares them against the registered outputs.
module tb_id_ex_stage;
  import mips_pkg::*;

`ifdef ID_EX_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, flush, in_valid;
  logic [31:0] instr, rs_data, rt_data;
  logic        exmem_wr, memwb_wr;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_res, memwb_res;
  logic        ex_valid, add_sub, ex_regwrite, ex_memread, ex_memwrite, ex_ovf_trap, ex_illegal;
  logic [31:0] alu_x, alu_y, ex_store_data;
  logic [4:0]  const_amt, ex_rd;
  logic [1:0]  amt_sel, logic_func, shift_func, final_func, ex_branch;

  typedef struct {
    ex_out_t v;
    string   name;
  } sb_item_t;

  sb_item_t sb[$];
  int       total = 0;
  int       bad   = 0;
  event     sample_now;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .instr(instr), .rs_data(rs_data), .rt_data(rt_data),
    .exmem_wr(exmem_wr), .exmem_rd(exmem_rd), .exmem_res(exmem_res),
    .memwb_wr(memwb_wr), .memwb_rd(memwb_rd), .memwb_res(memwb_res),
    .ex_valid(ex_valid), .alu_x(alu_x), .alu_y(alu_y),
    .const_amt(const_amt), .amt_sel(amt_sel), .logic_func(logic_func),
    .shift_func(shift_func), .add_sub(add_sub), .final_func(final_func),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_store_data(ex_store_data),
    .ex_branch(ex_branch), .ex_ovf_trap(ex_ovf_trap), .ex_illegal(ex_illegal)
  );

  function automatic logic [31:0] rtype(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                        logic [4:0] sh, logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                        logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // Valid adder-type record; directed code edits the fields that differ.
  function automatic ex_out_t ld(logic [31:0] x, logic [31:0] y, logic [4:0] rd,
                                 logic rw, logic [31:0] sd);
    ex_out_t e;
    e = '0;
    e.valid = 1'b1; e.x = x; e.y = y; e.rd = rd; e.regwrite = rw;
    e.store_data = sd; e.final_func = FF_ADD;
    return e;
  endfunction

  function automatic ex_out_t bubble();
    ex_out_t e;
    e = '0;
    e.final_func = FF_ADD;
    return e;
  endfunction

  task automatic push(input ex_out_t v, input string nm);
    sb_item_t it;
    it.v = v; it.name = nm;
    sb.push_back(it);
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] rsd, input logic [31:0] rtd);
    @(negedge clk);
    instr = ins; rs_data = rsd; rt_data = rtd; in_valid = 1'b1;
  endtask

  always begin
    sb_item_t it;
    ex_out_t  act;
    @(posedge clk or sample_now);
    #1;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      act = '{ex_valid, alu_x, alu_y, const_amt, amt_sel, logic_func, shift_func, add_sub,
              final_func, ex_rd, ex_regwrite, ex_memread, ex_memwrite, ex_store_data,
              ex_branch, ex_ovf_trap, ex_illegal};
      total++;
      if (act !== it.v) begin
        bad++;
        $display("FAIL %s got=%h exp=%h", it.name, act, it.v);
      end
    end
  end

  initial begin
    ex_out_t e, hold;
    rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
    instr = '0; rs_data = '0; rt_data = '0;
    exmem_wr = 1'b0; exmem_rd = '0; exmem_res = '0;
    memwb_wr = 1'b0; memwb_rd = '0; memwb_res = '0;

    @(negedge clk);
    push('0, "reset_state");

    // sra $4,$5,7
    issue(rtype(5'd0, 5'd5, 5'd4, 5'd7, F_SRA), 32'h100, 32'h8000_0000);
    rst = 1'b0;
    e = ld(32'h100, 32'h8000_0000, 5'd4, 1'b1, 32'h8000_0000);
    e.final_func = FF_SHIFT; e.shift_func = SH_SRA; e.const_amt = 5'd7; e.amt_sel = AMT_CONST;
    push(e, "sra");

    @(negedge clk);
    rst = 1'b1;
    push('0, "rst_async");
    -> sample_now;
    @(negedge clk);
    push('0, "rst_hold");

    // add $3,$1,$2 right after reset release
    issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, F_ADD), 32'd5, 32'd7);
    rst = 1'b0;
    e = ld(32'd5, 32'd7, 5'd3, 1'b1, 32'd7); e.ovf_trap = 1'b1;
    push(e, "add_after_rst");

    issue(rtype(5'd8, 5'd7, 5'd6, 5'd0, F_SRLV), 32'd3, 32'hF0);
    e = ld(32'd3, 32'hF0, 5'd6, 1'b1, 32'hF0);
    e.final_func = FF_SHIFT; e.shift_func = SH_SRL; e.amt_sel = AMT_REG;
    push(e, "srlv");

    issue(itype(OP_LUI, 5'd0, 5'd2, 16'h1234), 32'd0, 32'h55);
    e = ld(32'd0, 32'h0000_1234, 5'd2, 1'b1, 32'h55);
    e.final_func = FF_SHIFT; e.shift_func = SH_SLL; e.const_amt = 5'd16;
    push(e, "lui");

    issue(itype(OP_ADDI, 5'd1, 5'd9, 16'hFFFF), 32'd10, 32'h99);
    e = ld(32'd10, 32'hFFFF_FFFF, 5'd9, 1'b1, 32'h99); e.ovf_trap = 1'b1;
    push(e, "addi_sext");

    issue(itype(OP_ORI, 5'd1, 5'd10, 16'hFFFF), 32'd10, 32'h99);
    e = ld(32'd10, 32'h0000_FFFF, 5'd10, 1'b1, 32'h99);
    e.final_func = FF_LOGIC; e.logic_func = LG_OR;
    push(e, "ori_zext");

    issue(itype(OP_SLTI, 5'd1, 5'd11, 16'd5), 32'd10, 32'h99);
    e = ld(32'd10, 32'd5, 5'd11, 1'b1, 32'h99);
    e.final_func = FF_SLT; e.add_sub = 1'b1;
    push(e, "slti");

    issue(itype(OP_SW, 5'd29, 5'd7, 16'd8), 32'h1000, 32'hDEAD_BEEF);
    e = ld(32'h1000, 32'd8, 5'd0, 1'b0, 32'hDEAD_BEEF); e.memwrite = 1'b1;
    push(e, "sw");

    issue(itype(OP_LW, 5'd29, 5'd8, 16'hFFFC), 32'h1000, 32'h77);
    e = ld(32'h1000, 32'hFFFF_FFFC, 5'd8, 1'b1, 32'h77); e.memread = 1'b1;
    push(e, "lw");

    issue(itype(OP_BEQ, 5'd1, 5'd2, 16'h10), 32'h44, 32'h45);
    e = ld(32'h44, 32'h45, 5'd0, 1'b0, 32'h45); e.add_sub = 1'b1; e.branch = BR_EQ;
    push(e, "beq");

    issue(itype(OP_BNE, 5'd1, 5'd2, 16'h10), 32'h44, 32'h45);
    e = ld(32'h44, 32'h45, 5'd0, 1'b0, 32'h45); e.add_sub = 1'b1; e.branch = BR_NE;
    push(e, "bne");

    issue(itype(6'h3F, 5'd1, 5'd2, 16'h0), 32'h12, 32'h34);
    e = ld(32'h12, 32'h34, 5'd0, 1'b0, 32'h34); e.illegal = 1'b1;
    push(e, "illegal_op");

    issue(rtype(5'd1, 5'd2, 5'd0, 5'd0, F_ADD), 32'd5, 32'd7);
    e = ld(32'd5, 32'd7, 5'd0, 1'b0, 32'd7); e.ovf_trap = 1'b1;
    push(e, "add_rd0");

    // add $12,$5,$6 with both later stages writing $5
    issue(rtype(5'd5, 5'd6, 5'd12, 5'd0, F_ADD), 32'h11, 32'h22);
    exmem_wr = 1'b1; exmem_rd = 5'd5; exmem_res = 32'hAAAA_0001;
    memwb_wr = 1'b1; memwb_rd = 5'd5; memwb_res = 32'hBBBB_0002;
    e = ld(FWD ? 32'hAAAA_0001 : 32'h11, 32'h22, 5'd12, 1'b1, 32'h22); e.ovf_trap = 1'b1;
    push(e, "fwd_exmem_prio");

    issue(rtype(5'd0, 5'd6, 5'd13, 5'd0, F_ADD), 32'h33, 32'h22);
    exmem_wr = 1'b1; exmem_rd = 5'd0; exmem_res = 32'hCCCC_0003;
    memwb_wr = 1'b1; memwb_rd = 5'd0; memwb_res = 32'hDDDD_0004;
    e = ld(32'h33, 32'h22, 5'd13, 1'b1, 32'h22); e.ovf_trap = 1'b1;
    push(e, "fwd_idx0");

    // sw $6,0($4): MEM/WB hits rt; EX/MEM matches but is not writing
    issue(itype(OP_SW, 5'd4, 5'd6, 16'h0), 32'h40, 32'h22);
    exmem_wr = 1'b0; exmem_rd = 5'd6; exmem_res = 32'hEEEE_0005;
    memwb_wr = 1'b1; memwb_rd = 5'd6; memwb_res = 32'h6666_0006;
    e = ld(32'h40, 32'h0, 5'd0, 1'b0, FWD ? 32'h6666_0006 : 32'h22); e.memwrite = 1'b1;
    push(e, "fwd_memwb_store");

    issue(rtype(5'd1, 5'd2, 5'd14, 5'd0, F_XOR), 32'h0F0F_0000, 32'h00FF_00FF);
    exmem_wr = 1'b0; exmem_rd = '0; exmem_res = '0;
    memwb_wr = 1'b0; memwb_rd = '0; memwb_res = '0;
    hold = ld(32'h0F0F_0000, 32'h00FF_00FF, 5'd14, 1'b1, 32'h00FF_00FF);
    hold.final_func = FF_LOGIC; hold.logic_func = LG_XOR;
    push(hold, "xor");

    for (int i = 0; i < 3; i++) begin
      issue(rtype(5'd6, 5'd7, 5'd5, 5'd3, F_SUB), 32'h9000 + i, 32'h8000 + i);
      stall = 1'b1;
      push(hold, $sformatf("stall_%0d", i));
    end

    issue(rtype(5'd6, 5'd7, 5'd5, 5'd3, F_SUB), 32'h9, 32'h8);
    stall = 1'b1; flush = 1'b1;
    push(bubble(), "flush_over_stall");

    issue(itype(OP_ANDI, 5'd1, 5'd15, 16'h8001), 32'd1, 32'd2);
    stall = 1'b0; flush = 1'b0;
    e = ld(32'd1, 32'h0000_8001, 5'd15, 1'b1, 32'd2);
    e.final_func = FF_LOGIC; e.logic_func = LG_AND;
    push(e, "andi");

    @(negedge clk);
    in_valid = 1'b0;
    push(bubble(), "in_valid_low");

    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d left exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
